// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch sequencer for a dual-port synchronous instruction ROM.
// Each issue reads the pair (PC, PC+4) on ports A/B. The results land in a
// small prefetch FIFO together with their PCs. The FIFO head is offered to
// decode through a valid/ready handshake. A redirect pulse flushes the FIFO
// and any read in flight, then restarts fetch at the new PC.
// Optional build macro IMEM_FETCH_STATS_EN adds the stat_fetched and
// stat_flushed counters.
module imem_fetch_ctrl #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addrA,
  output logic [31:0] rom_addrB,
  input  logic [31:0] rom_doutA,
  input  logic [31:0] rom_doutB,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
`ifdef IMEM_FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PAIR = PTR_W'(DEPTH - 2);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_issued_pc;
  logic [31:0]      r_idle_pc;
  logic             r_inflight;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_data_mem [DEPTH];
  logic [31:0]      r_pc_mem   [DEPTH];

  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  int               w_credit;
  logic [31:0]      w_redirect_pc;
  logic [PTR_W-1:0] w_head_next;
  logic [PTR_W-1:0] w_tail_next;
  logic [PTR_W-1:0] w_tail_odd;
  logic [1:0]       w_unused_lsbs;

  assign w_valid       = (r_count != '0);
  assign w_pop         = w_valid && instr_ready;
  // A response still in flight is dropped when a redirect arrives in the same cycle.
  assign w_push        = r_inflight && !redirect_valid;
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused_lsbs = redirect_pc[1:0];
  assign w_head_next   = (r_head == LAST_IDX) ? '0 : r_head + PTR_W'(1);
  // The tail only ever moves in pairs from 0, so it stays even and tail+1 never wraps.
  assign w_tail_next   = (r_tail == LAST_PAIR) ? '0 : r_tail + PTR_W'(2);
  assign w_tail_odd    = r_tail + PTR_W'(1);

  // Credit check: occupancy after this cycle's pop plus the pair still in flight.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    w_credit = 0;
    w_issue  = 1'b0;
    w_credit = int'(r_count) - int'(w_pop) + 2 * int'(r_inflight);
    w_issue  = !reset && !redirect_valid && (w_credit <= DEPTH - 2);
  end

  // Fetch PC, in-flight flag and FIFO bookkeeping; redirect outranks everything but reset.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_issued_pc <= RESET_PC;
      r_idle_pc   <= RESET_PC;
      r_inflight  <= 1'b0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      r_idle_pc  <= w_redirect_pc;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc  <= r_fetch_pc + 32'd8;
        r_issued_pc <= r_fetch_pc;
      end
      if (w_pop) begin
        r_head    <= w_head_next;
        r_idle_pc <= r_pc_mem[r_head];
      end
      if (w_push) begin
        r_tail <= w_tail_next;
        // The credit rule leaves room for a full pair whenever a push lands.
        assert (int'(r_count) - int'(w_pop) + 2 <= DEPTH);
      end
      r_count <= r_count + (w_push ? CNT_W'(2) : '0) - (w_pop ? CNT_W'(1) : '0);
    end
  end

  // FIFO storage: port A word goes ahead of port B word.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; r_count gates every read, so stale contents are never visible.
    if (!reset && w_push) begin
      r_data_mem[r_tail]     <= rom_doutA;
      r_pc_mem[r_tail]       <= r_issued_pc;
      r_data_mem[w_tail_odd] <= rom_doutB;
      r_pc_mem[w_tail_odd]   <= r_issued_pc + 32'd4;
    end
  end

  assign rom_addrA   = r_fetch_pc;
  assign rom_addrB   = r_fetch_pc + 32'd4;
  assign instr_valid = w_valid;
  assign instr_data  = w_valid ? r_data_mem[r_head] : NOP;
  assign instr_pc    = w_valid ? r_pc_mem[r_head] : r_idle_pc;

`ifdef IMEM_FETCH_STATS_EN
  // Statistics: words written into the FIFO, and words thrown away by redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (w_push) begin
        stat_fetched <= stat_fetched + 32'd2;
      end
      // On a redirect, w_credit counts the entries left after the pop plus the pair in flight.
      if (redirect_valid) begin
        stat_flushed <= stat_flushed + 32'(w_credit);
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
